// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates one write requester (JTAG loader) and one read requester onto a single-port memory.
// Latency: grants are combinational in the request cycle; read data returns one cycle after the read grant.
// Backpressure: a denied requester holds its request; after MAX_WAIT denied read cycles the read wins.
//
// Ports:
//   clk_i, rst_ni                        clock, synchronous active-low reset
//   wr_req_i/wr_addr_i/wr_data_i         write request; wr_gnt_o accepts it this cycle
//   rd_req_i/rd_addr_i                   read request; rd_gnt_o accepts it this cycle
//   rd_valid_o/rd_data_o                 read response (rd_data_o holds the last response when idle)
//   mem_addr_o/mem_we_o/mem_data_o       memory command, mem_data_i is the registered read data
//   wr_count_o                           saturating count of granted writes
module mem_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_gnt_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [15:0]       wr_count_o
);

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    logic [3:0]        wait_q;
    logic              forced;
    logic              rd_vld_q;
    logic [DATA_W-1:0] hold_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [15:0]       wr_cnt_q;

    // Forced-read mode is derived from the registered starvation counter, so
    // it clears together with the counter.
    assign forced = (wait_q >= MAX_WAIT_L);

    always_comb begin
        // Writes normally win; a starved read overrides a simultaneous write.
        // A write with no competing read is still granted in forced mode.
        wr_gnt_o = rst_ni & wr_req_i & ~(forced & rd_req_i);
        rd_gnt_o = rst_ni & rd_req_i & ~wr_gnt_o;
    end

    always_comb begin
        mem_addr_o = last_addr_q;
        mem_we_o   = 1'b0;
        mem_data_o = '0;
        if (wr_gnt_o) begin
            mem_addr_o = wr_addr_i;
            mem_we_o   = 1'b1;
            mem_data_o = wr_data_i;
        end else if (rd_gnt_o) begin
            mem_addr_o = rd_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_q      <= '0;
            rd_vld_q    <= 1'b0;
            hold_q      <= '0;
            last_addr_q <= '0;
            wr_cnt_q    <= '0;
        end else begin
            // Count consecutive denied read cycles; any grant or idle read clears it.
            if (rd_req_i && !rd_gnt_o) begin
                if (wait_q != 4'hF) begin
                    wait_q <= wait_q + 4'd1;
                end
            end else begin
                wait_q <= '0;
            end

            rd_vld_q <= rd_gnt_o;
            if (rd_vld_q) begin
                hold_q <= mem_data_i;
            end

            if (wr_gnt_o) begin
                last_addr_q <= wr_addr_i;
                if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_q <= wr_cnt_q + 16'd1;
                end
            end else if (rd_gnt_o) begin
                last_addr_q <= rd_addr_i;
            end
        end
    end

    // A valid pulse still in flight when reset asserts is suppressed at once.
    assign rd_valid_o = rd_vld_q & rst_ni;
    assign rd_data_o  = rd_valid_o ? mem_data_i : hold_q;
    assign wr_count_o = wr_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   wr_count;

    int n_checks = 0;
    int n_err    = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .wr_req_i   (wr_req),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_gnt_o   (wr_gnt),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .rd_gnt_o   (rd_gnt),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .mem_addr_o (mem_addr),
        .mem_we_o   (mem_we),
        .mem_data_o (mem_wdata),
        .mem_data_i (mem_rdata),
        .wr_count_o (wr_count)
    );

    always #5 clk = ~clk;

    // Single-port memory with a one-cycle registered (read-first) read.
    logic [DW-1:0] tb_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    // Reference model state: what the arbiter should look like this cycle.
    int            m_wait = 0;
    bit            m_vld  = 0;
    logic [DW-1:0] m_pend = '0;
    logic [DW-1:0] m_hold = '0;
    int            m_cnt  = 0;
    logic [AW-1:0] m_last = '0;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rst, input bit wr, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input bit rd, input logic [AW-1:0] ra);
        bit            e_wg, e_rg, e_vld;
        logic [AW-1:0] e_addr;
        @(negedge clk);
        rst_ni  = rst;
        wr_req  = wr;
        wr_addr = wa;
        wr_data = wd;
        rd_req  = rd;
        rd_addr = ra;
        #1;
        e_wg   = rst && wr && !((m_wait >= MW) && rd);
        e_rg   = rst && rd && !e_wg;
        e_vld  = m_vld && rst;
        e_addr = e_wg ? wa : (e_rg ? ra : m_last);
        chk("wr_gnt",   32'(wr_gnt),    32'(e_wg));
        chk("rd_gnt",   32'(rd_gnt),    32'(e_rg));
        chk("mem_we",   32'(mem_we),    32'(e_wg));
        chk("mem_addr", 32'(mem_addr),  32'(e_addr));
        chk("mem_data", 32'(mem_wdata), e_wg ? 32'(wd) : 32'd0);
        chk("rd_valid", 32'(rd_valid),  32'(e_vld));
        chk("rd_data",  32'(rd_data),   e_vld ? 32'(m_pend) : 32'(m_hold));
        chk("wr_count", 32'(wr_count),  32'(m_cnt));
        if (!rst) begin
            m_wait = 0; m_vld = 0; m_hold = '0; m_cnt = 0; m_last = '0;
        end else begin
            if (m_vld) m_hold = m_pend;
            m_vld = e_rg;
            if (e_rg) begin
                m_pend = ref_mem[ra];
                m_last = ra;
            end
            if (e_wg) begin
                ref_mem[wa] = wd;
                m_last      = wa;
                if (m_cnt < 65535) m_cnt++;
            end
            if (rd && !e_rg) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
            else             m_wait = 0;
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        rst_ni = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);

        // Reset state, with requests asserted: nothing may be granted.
        step(1'b0, 1'b1, 10'h005, 8'h77, 1'b1, 10'h006);
        chk("rst_no_wgnt", 32'(wr_gnt), 32'd0);
        chk("rst_no_rgnt", 32'(rd_gnt), 32'd0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0);

        // Write only, on the first edge after release.
        step(1'b1, 1'b1, 10'h005, 8'hA5, 1'b0, '0);
        chk("w_only_gnt",  32'(wr_gnt),   32'd1);
        chk("w_only_we",   32'(mem_we),   32'd1);
        chk("w_only_addr", 32'(mem_addr), 32'h005);
        idle();
        chk("w_only_cnt",  32'(wr_count), 32'd1);
        chk("idle_hold_addr", 32'(mem_addr), 32'h005);

        // Read only after preloading 0x3C at 0x005.
        step(1'b1, 1'b1, 10'h005, 8'h3C, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 10'h005);
        chk("r_only_gnt", 32'(rd_gnt), 32'd1);
        idle();
        chk("r_only_vld",  32'(rd_valid), 32'd1);
        chk("r_only_data", 32'(rd_data),  32'h3C);
        idle();
        chk("r_hold_vld",  32'(rd_valid), 32'd0);
        chk("r_hold_data", 32'(rd_data),  32'h3C);

        // Prefill addresses 0..15 with random data.
        for (int a = 0; a < 16; a++)
            step(1'b1, 1'b1, 10'(a), 8'($urandom), 1'b0, '0);

        // Contention: four writes, then the starved read, then writes resume.
        idle();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 10'(i), 8'(8'h50 + i), 1'b1, 10'h003);
            chk("cont_wgnt", 32'(wr_gnt), 32'((i % 5) != 4));
            chk("cont_rgnt", 32'(rd_gnt), 32'((i % 5) == 4));
        end
        idle();

        // Streaming reads over addresses 0..7.
        for (int a = 0; a < 8; a++)
            step(1'b1, 1'b1, 10'(a), 8'(8'h10 + a), 1'b0, '0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, '0, '0, (i < 8), 10'(i));
            chk("strm_gnt", 32'(rd_gnt),   32'(i < 8));
            chk("strm_vld", 32'(rd_valid), 32'(i > 0));
            if (i > 0) chk("strm_data", 32'(rd_data), 32'(8'h10 + i - 1));
        end

        // Reset in the cycle after a read grant.
        step(1'b1, 1'b0, '0, '0, 1'b1, 10'h002);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0);
        chk("rstmid_vld", 32'(rd_valid), 32'd0);
        idle();
        chk("rstmid_vld_after", 32'(rd_valid), 32'd0);
        chk("rstmid_data",      32'(rd_data),  32'd0);
        chk("rstmid_cnt",       32'(wr_count), 32'd0);
        chk("rstmid_addr",      32'(mem_addr), 32'd0);
        idle();
        chk("rstmid_no_late", 32'(rd_valid), 32'd0);

        // Randomized traffic, including requests dropped before grant.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 49) != 0), 1'($urandom), 10'($urandom_range(0, 15)),
                 8'($urandom), 1'($urandom), 10'($urandom_range(0, 15)));
        idle();

        // Saturation of the write counter.
        step(1'b0, 1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 65537; i++)
            step(1'b1, 1'b1, 10'(i % 16), 8'(i), 1'b0, '0);
        idle();
        chk("sat_cnt", 32'(wr_count), 32'hFFFF);
        step(1'b1, 1'b1, 10'h001, 8'h01, 1'b0, '0);
        idle();
        chk("sat_hold", 32'(wr_count), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
